// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states
// and the CLAIM result layout.
package irq_ctrl_pkg;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_ENABLE   = 3'd1;
  localparam logic [2:0] ADDR_EDGE     = 3'd2;
  localparam logic [2:0] ADDR_CLAIM    = 3'd3;
  localparam logic [2:0] ADDR_COMPLETE = 3'd4;

  localparam int CLAIM_VALID_BIT = 31;
  localparam int ID_W            = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_IN_SERVICE
  } state_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of
// the lowest-numbered one.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    i_req,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Wishbone-attached interrupt controller: synchronized sources, edge/level
// pending logic, lowest-index arbitration and a claim/complete handshake.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [2:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] r_sync1, r_sync2, r_sync3;
  logic [NUM_SRC-1:0] r_pend, r_enable, r_edge;
  logic               r_ack;
  logic [31:0]        r_dat;
  state_t             r_state;
  logic               r_irq;
  logic [ID_W-1:0]    r_isr_id;

  logic               w_req, w_wr, w_rd;
  logic [NUM_SRC-1:0] w_rise, w_active, w_clr, w_pend_next;
  logic               w_valid, w_claim, w_complete;
  logic [ID_W-1:0]    w_id;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_unused = ^wb_dat_i;

  // A new request is only accepted while ack is low, so acks never run back to back.
  assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr   = w_req & wb_we_i;
  assign w_rd   = w_req & ~wb_we_i;

  assign w_rise   = r_sync2 & ~r_sync3;
  assign w_active = r_pend & r_enable;

  irq_prio_enc #(.N(NUM_SRC)) u_prio (
    .i_req   (w_active),
    .o_valid (w_valid),
    .o_id    (w_id)
  );

  assign w_claim    = w_rd && (wb_adr_i == ADDR_CLAIM) && (r_state == ST_ASSERT) && w_valid;
  assign w_complete = w_wr && (wb_adr_i == ADDR_COMPLETE) && (r_state == ST_IN_SERVICE) &&
                      (wb_dat_i[ID_W-1:0] == r_isr_id);

  always_comb begin
    w_clr = '0;
    if (w_wr && (wb_adr_i == ADDR_PENDING))
      w_clr = w_clr | wb_dat_i[NUM_SRC-1:0];
    if (w_claim)
      w_clr = w_clr | (NUM_SRC'(1) << w_id);
  end

  // Edge bits: a fresh rise beats a simultaneous clear. Level bits track the input.
  assign w_pend_next = (r_edge & ((r_pend & ~w_clr) | w_rise)) | (~r_edge & r_sync2);

  always_comb begin
    w_rdata = '0;
    case (wb_adr_i)
      ADDR_PENDING: w_rdata = 32'(r_pend);
      ADDR_ENABLE:  w_rdata = 32'(r_enable);
      ADDR_EDGE:    w_rdata = 32'(r_edge);
      ADDR_CLAIM: begin
        if (w_claim) begin
          w_rdata[CLAIM_VALID_BIT] = 1'b1;
          w_rdata[ID_W-1:0]        = w_id;
        end
      end
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync3  <= '0;
      r_pend   <= '0;
      r_enable <= '0;
      r_edge   <= '0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_sync1 <= irq_src_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pend  <= w_pend_next;
      r_ack   <= w_req;
      r_dat   <= w_rd ? w_rdata : 32'd0;
      if (w_wr && (wb_adr_i == ADDR_ENABLE))
        r_enable <= wb_dat_i[NUM_SRC-1:0];
      if (w_wr && (wb_adr_i == ADDR_EDGE))
        r_edge <= wb_dat_i[NUM_SRC-1:0];
    end
  end

  // irq_o is registered alongside the state so it is high exactly in ASSERT.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= ST_IDLE;
      r_irq    <= 1'b0;
      r_isr_id <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state <= ST_ASSERT;
            r_irq   <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (w_claim) begin
            r_state  <= ST_IN_SERVICE;
            r_isr_id <= w_id;
            r_irq    <= 1'b0;
          end else if (!w_valid) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
          end
        end
        ST_IN_SERVICE: begin
          r_irq <= 1'b0;
          if (w_complete)
            r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;

endmodule
